// File: rtl/amx_frame_pkg.sv
// rtl/amx_frame_pkg.sv - shared types, constants and CRC-8 helper for the frame transmitter
// Purpose: frame FSM state encoding, default SYNC/IDLE byte values, CRC-8
//          polynomial and the one-byte CRC-8 update used by the checksum path.
// Ports:   none (package).
package amx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  // MSB-first CRC-8 over one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/amx_frame_tx_if.sv
// rtl/amx_frame_tx_if.sv - host/framer signal bundle for the frame transmitter
// Purpose: groups the payload push handshake, send request and framed byte
//          output of amx_frame_tx.
// Signals: in_data/in_valid/in_ready (payload push), send, busy,
//          data_out/data_strobe (framed byte stream), fifo_count.
// Modports: master = host side, slave = framer side.
interface amx_frame_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                  in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        send;
  logic                        busy;
  logic [7:0]                  data_out;
  logic                        data_strobe;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output in_data, in_valid, send,
    input  in_ready, busy, data_out, data_strobe, fifo_count
  );

  modport slave (
    input  in_data, in_valid, send,
    output in_ready, busy, data_out, data_strobe, fifo_count
  );
endinterface

// File: rtl/amx_byte_fifo.sv
// rtl/amx_byte_fifo.sv - power-of-two byte FIFO with occupancy count
// Purpose: payload buffer for the framer; also intended for a receive deframer.
// Ports:   clk, rst (sync, active-high); push_data/push_valid (write, ignored
//          when full); pop (read, ignored when empty); pop_data (head byte,
//          combinational); count, full, empty (from registered count).
module amx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             push_data,
  input  logic                   push_valid,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered count, so a pop in the same cycle
  // does not open room for a push.
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push_valid && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/amx_frame_tx.sv
// rtl/amx_frame_tx.sv - byte framer: SYNC, LEN, payload, checksum
// Purpose: buffers payload bytes and, on send, emits one registered frame byte
//          per clock with no gaps. Optional macro AMX_FRAME_TX_CRC8_EN selects
//          a CRC-8 checksum byte instead of the mod-256 additive checksum.
// Ports:   clk, rst (sync, active-high); bus (amx_frame_tx_if.slave):
//          in_data/in_valid/in_ready, send, busy, data_out, data_strobe,
//          fifo_count.
module amx_frame_tx
  import amx_frame_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEF
) (
  input logic           clk,
  input logic           rst,
  amx_frame_tx_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  frame_state_e state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    data_q, data_d;
  logic          strobe_q, strobe_d;

  logic          pop;
  logic [7:0]    pop_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  function automatic logic [7:0] csum_start(input logic [7:0] len_byte);
`ifdef AMX_FRAME_TX_CRC8_EN
    return crc8_byte(8'h00, len_byte);
`else
    return len_byte;
`endif
  endfunction

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef AMX_FRAME_TX_CRC8_EN
    return crc8_byte(acc, b);
`else
    return acc + b;
`endif
  endfunction

  amx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_data  (bus.in_data),
    .push_valid (bus.in_valid),
    .pop        (pop),
    .pop_data   (pop_data),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign bus.in_ready    = ~fifo_full;
  assign bus.fifo_count  = fifo_count;
  assign bus.data_out    = data_q;
  assign bus.data_strobe = strobe_q;
  // Every frame byte is strobed, so busy is exactly the strobe.
  assign bus.busy        = strobe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      csum_q   <= 8'h00;
      data_q   <= IDLE_BYTE;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  // Outputs are computed for the current state and registered, so the byte
  // for a state appears one cycle after the state is entered.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    data_d   = IDLE_BYTE;
    strobe_d = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Length is frozen here; later pushes wait for the next frame.
        if (bus.send && !fifo_empty) begin
          len_d   = fifo_count;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        data_d   = SYNC_BYTE;
        strobe_d = 1'b1;
        csum_d   = csum_start(8'(len_q));
        state_d  = ST_LEN;
      end
      ST_LEN: begin
        data_d   = 8'(len_q);
        strobe_d = 1'b1;
        cnt_d    = '0;
        state_d  = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        pop      = 1'b1;
        data_d   = pop_data;
        strobe_d = 1'b1;
        csum_d   = csum_step(csum_q, pop_data);
        cnt_d    = cnt_q + 1'b1;
        if ((cnt_q + 1'b1) == len_q) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        data_d   = csum_q;
        strobe_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_amx_frame_tx.sv
// tb/tb_amx_frame_tx.sv - self-checking bench for amx_frame_tx
module tb_amx_frame_tx;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  amx_frame_tx_if #(.FIFO_DEPTH(DEPTH)) bus();

  amx_frame_tx #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_BYTE  (8'hA5),
    .IDLE_BYTE  (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];

  typedef struct {
    int         n;
    logic [7:0] p [4];
    logic [7:0] sum;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_check(input logic [7:0] msg[$]);
`ifdef AMX_FRAME_TX_CRC8_EN
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb  = crc[7] ^ msg[i][b];
        crc = {crc[6:0], 1'b0};
        if (fb) crc = crc ^ 8'h07;
      end
    end
    return crc;
`else
    int s;
    s = 0;
    foreach (msg[i]) s += int'(msg[i]);
    return 8'(s % 256);
`endif
  endfunction

  task automatic build_expected();
    logic [7:0] msg[$];
    msg = {};
    exp_q = {};
    msg.push_back(8'(mq.size()));
    foreach (mq[i]) msg.push_back(mq[i]);
    exp_q.push_back(8'hA5);
    foreach (msg[i]) exp_q.push_back(msg[i]);
    exp_q.push_back(ref_check(msg));
    mq = {};
  endtask

  task automatic push(input logic [7:0] d);
    chk("in_ready", bus.in_ready, (mq.size() < DEPTH));
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(d);
  endtask

  task automatic start_send();
    bus.send = 1'b1;
    step();
    bus.send = 1'b0;
  endtask

  // Called just after the edge that sampled send; inject >= 0 pushes 8'h55
  // and re-asserts send in the cycle producing byte number inject.
  task automatic expect_frame(input int inject);
    chk("pre_strobe", bus.data_strobe, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == inject) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        bus.send     = 1'b1;
      end
      step();
      if (i == inject) begin
        bus.in_valid = 1'b0;
        bus.send     = 1'b0;
        mq.push_back(8'h55);
      end
      chk($sformatf("byte%0d", i), bus.data_out, exp_q[i]);
      chk($sformatf("strobe%0d", i), bus.data_strobe, 1);
      chk($sformatf("busy%0d", i), bus.busy, 1);
    end
    step();
    chk("end_data", bus.data_out, 8'h00);
    chk("end_strobe", bus.data_strobe, 0);
    chk("end_busy", bus.busy, 0);
    chk("end_count", bus.fifo_count, mq.size());
  endtask

  initial begin
    vecs[0] = '{3, '{8'h01, 8'h02, 8'h03, 8'h00}, 8'h09};
    vecs[1] = '{1, '{8'h31, 8'h00, 8'h00, 8'h00}, 8'h32};
    vecs[2] = '{2, '{8'hFF, 8'hFF, 8'h00, 8'h00}, 8'h00};
    vecs[3] = '{4, '{8'h80, 8'h7F, 8'h01, 8'h00}, 8'h04};
    vecs[4] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h01};
    vecs[5] = '{4, '{8'h10, 8'h20, 8'h30, 8'h40}, 8'hA4};

    rst          = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.send     = 1'b0;
    step();
    step();
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_strobe", bus.data_strobe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    step();

    // Table-driven frames.
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < vecs[k].n; j++) push(vecs[k].p[j]);
      chk("tbl_count", bus.fifo_count, vecs[k].n);
      build_expected();
`ifndef AMX_FRAME_TX_CRC8_EN
      exp_q[exp_q.size() - 1] = vecs[k].sum;
`endif
      start_send();
      expect_frame(-1);
    end

    // Send with an empty FIFO is ignored.
    chk("empty_count", bus.fifo_count, 0);
    start_send();
    for (int j = 0; j < 4; j++) begin
      step();
      chk("empty_strobe", bus.data_strobe, 0);
      chk("empty_busy", bus.busy, 0);
      chk("empty_data", bus.data_out, 8'h00);
    end

    // Fill to DEPTH, ninth push dropped, maximum-length frame.
    for (int j = 0; j < DEPTH + 1; j++) push(8'hFF);
    chk("full_count", bus.fifo_count, DEPTH);
    chk("full_in_ready", bus.in_ready, 0);
    build_expected();
    start_send();
    expect_frame(-1);

    // Push and send during payload: send ignored, byte kept for next frame.
    push(8'h11);
    push(8'h22);
    build_expected();
    start_send();
    expect_frame(3);
    build_expected();
    start_send();
    expect_frame(-1);

    // Reset in the cycle after the LEN byte.
    push(8'h44);
    push(8'h66);
    start_send();
    step();
    chk("rstm_sync", bus.data_out, 8'hA5);
    step();
    chk("rstm_len", bus.data_out, 8'h02);
    step();
    chk("rstm_p0", bus.data_out, 8'h44);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mq = {};
    chk("rstm_data", bus.data_out, 8'h00);
    chk("rstm_strobe", bus.data_strobe, 0);
    chk("rstm_busy", bus.busy, 0);
    chk("rstm_count", bus.fifo_count, 0);
    chk("rstm_in_ready", bus.in_ready, 1);
    step();

    // Randomised traffic against the queue model.
    for (int it = 0; it < 40; it++) begin
      int  k;
      logic v;
      k = $urandom_range(0, DEPTH + 3);
      for (int j = 0; j < k; j++) begin
        v = ($urandom_range(0, 3) != 0);
        chk("rnd_in_ready", bus.in_ready, (mq.size() < DEPTH));
        chk("rnd_count", bus.fifo_count, mq.size());
        bus.in_valid = v;
        bus.in_data  = 8'($urandom);
        step();
        bus.in_valid = 1'b0;
        if (v && mq.size() < DEPTH) mq.push_back(bus.in_data);
      end
      if (mq.size() == 0) begin
        start_send();
        for (int j = 0; j < 3; j++) begin
          step();
          chk("rnd_idle_strobe", bus.data_strobe, 0);
        end
      end else begin
        build_expected();
        start_send();
        expect_frame(-1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
